// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding, default geometry and sizing helpers for serial_add_seq
package serial_add_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
  localparam int WIDTH_DEF = 8;
  localparam int SLICE_DEF = 2;
  function automatic int nslices(input int w, input int s);
    return w / s;
  endfunction
  function automatic int cnt_w(input int w, input int s);
    return (w / s) > 1 ? $clog2(w / s) : 1;
  endfunction
endpackage

// File: rtl/add_slice.sv
// add_slice: combinational SLICE-bit adder with carry in/out
module add_slice #(
  parameter int SLICE = 2
) (
  input  logic [SLICE-1:0] lhs,
  input  logic [SLICE-1:0] rhs,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);
  assign {cout, sum} = {1'b0, lhs} + {1'b0, rhs} + {{SLICE{1'b0}}, cin};
endmodule

// File: rtl/serial_add_seq.sv
// serial_add_seq: adds two WIDTH-bit operands SLICE bits per cycle, LSB first; SERIAL_ADD_OVF_EN adds io_out_ovf
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_lhs,
  input  logic [WIDTH-1:0] io_in_rhs,
  input  logic             io_in_cin,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_sum,
`ifdef SERIAL_ADD_OVF_EN
  output logic             io_out_ovf,
`endif
  output logic             io_out_cout
);
  localparam int NS = nslices(WIDTH, SLICE);
  localparam int CW = cnt_w(WIDTH, SLICE);
  if (SLICE < 1 || WIDTH % SLICE != 0) begin : g_chk
    $error("WIDTH must be a positive multiple of SLICE");
  end
  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] lhs_sh, rhs_sh, sum_sh;
  logic             carry, accept, last, s_cout;
  logic [SLICE-1:0] s_sum;
  add_slice #(.SLICE(SLICE)) u_slice (
    .lhs  (lhs_sh[SLICE-1:0]),
    .rhs  (rhs_sh[SLICE-1:0]),
    .cin  (carry),
    .sum  (s_sum),
    .cout (s_cout)
  );
  assign io_in_ready  = state == S_IDLE || (state == S_DONE && io_out_ready);
  assign accept       = io_in_valid && io_in_ready;
  assign last         = cnt == CW'(NS - 1);
  assign io_out_valid = state == S_DONE;
  assign io_out_sum   = sum_sh;
  assign io_out_cout  = carry;
  // accept wins over DONE->IDLE so a waiting producer starts without a bubble
  always_comb begin
    state_nxt = accept ? S_RUN :
                (state == S_RUN && last) ? S_DONE :
                (state == S_DONE && io_out_ready) ? S_IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      lhs_sh <= '0;
      rhs_sh <= '0;
      sum_sh <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lhs_sh <= io_in_lhs;
        rhs_sh <= io_in_rhs;
        carry  <= io_in_cin;
        cnt    <= '0;
      end else if (state == S_RUN) begin
        lhs_sh <= lhs_sh >> SLICE;
        rhs_sh <= rhs_sh >> SLICE;
        sum_sh <= WIDTH'({s_sum, sum_sh} >> SLICE);
        carry  <= s_cout;
        cnt    <= cnt + CW'(1);
      end
    end
  end
`ifdef SERIAL_ADD_OVF_EN
  logic lhs_msb, rhs_msb;
  always_ff @(posedge clk) begin
    if (reset) begin
      lhs_msb <= 1'b0;
      rhs_msb <= 1'b0;
    end else if (accept) begin
      lhs_msb <= io_in_lhs[WIDTH-1];
      rhs_msb <= io_in_rhs[WIDTH-1];
    end
  end
  assign io_out_ovf = io_out_valid && lhs_msb == rhs_msb && sum_sh[WIDTH-1] != lhs_msb;
`endif
endmodule

// File: tb/tb_serial_add_seq.sv
// tb_serial_add_seq: scoreboard bench for serial_add_seq (WIDTH=8, SLICE=2), directed vectors
module tb_serial_add_seq;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0, in_ready, in_cin = 1'b0;
  logic [7:0] in_lhs = '0, in_rhs = '0, out_sum;
  logic       out_valid, out_ready = 1'b1, out_cout, out_ovf;
  typedef struct packed {logic [7:0] sum; logic cout; logic ovf;} res_t;
  res_t sb[$];
  int   lat[$];
  int   cyc = 0, n_cmp = 0, n_bad = 0;
  bit   seen = 0, exp_low = 0;
  serial_add_seq #(.WIDTH(8), .SLICE(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .io_in_valid  (in_valid),
    .io_in_ready  (in_ready),
    .io_in_lhs    (in_lhs),
    .io_in_rhs    (in_rhs),
    .io_in_cin    (in_cin),
    .io_out_valid (out_valid),
    .io_out_ready (out_ready),
    .io_out_sum   (out_sum),
`ifdef SERIAL_ADD_OVF_EN
    .io_out_ovf   (out_ovf),
`endif
    .io_out_cout  (out_cout)
  );
`ifndef SERIAL_ADD_OVF_EN
  assign out_ovf = 1'b0;
`endif
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // monitor: samples on the falling edge; a fire seen here completes on the next rising edge
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (exp_low) check("valid_drop", {31'd0, out_valid}, 0);
      exp_low = 0;
      if (out_valid && !seen) begin
        seen = 1;
        if (lat.size() != 0) check("latency", cyc - lat.pop_front(), 4);
        else check("spurious_valid", {31'd0, out_valid}, 0);
      end
      if (out_valid) begin
        if (sb.size() == 0) check("unexpected_result", {31'd0, out_valid}, 0);
        else begin
          check("sum", {24'd0, out_sum}, {24'd0, sb[0].sum});
          check("cout", {31'd0, out_cout}, {31'd0, sb[0].cout});
`ifdef SERIAL_ADD_OVF_EN
          check("ovf", {31'd0, out_ovf}, {31'd0, sb[0].ovf});
`endif
          if (!out_ready) check("in_ready_stall", {31'd0, in_ready}, 0);
          else begin
            void'(sb.pop_front());
            seen = 0;
            exp_low = !(in_valid && in_ready);
          end
        end
      end
    end
  end
  task automatic send(input logic [7:0] l, input logic [7:0] r, input logic c,
                      input logic [7:0] es, input logic ec, input logic eo);
    bit ok = 0;
    @(posedge clk); #1;
    in_lhs = l; in_rhs = r; in_cin = c; in_valid = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (ok) begin
      sb.push_back(res_t'{es, ec, eo});
      lat.push_back(cyc + 1);
    end else check("accept_timeout", {31'd0, in_ready}, 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check("drain_timeout", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask
  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    sb.delete();
    lat.delete();
    seen = 0;
    exp_low = 0;
    @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_sum", {24'd0, out_sum}, 0);
    check("rst_cout", {31'd0, out_cout}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    check("rst_ovf", {31'd0, out_ovf}, 0);
  endtask
  initial begin
    pulse_reset();
    send(8'h12, 8'h34, 0, 8'h46, 0, 0);
    drain();
    send(8'hFF, 8'h01, 0, 8'h00, 1, 0);
    send(8'hFF, 8'hFF, 1, 8'hFF, 1, 0);
    drain();
    out_ready = 0;
    send(8'h5A, 8'h3C, 1, 8'h97, 0, 1);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check("bp_valid", {31'd0, out_valid}, 1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1;
    drain();
    send(8'h80, 8'h80, 0, 8'h00, 1, 1);
    send(8'h01, 8'h02, 1, 8'h04, 0, 0);
    drain();
    send(8'h33, 8'h44, 0, 8'h77, 0, 0);
    @(posedge clk);
    pulse_reset();
    send(8'h0A, 8'h05, 0, 8'h0F, 0, 0);
    drain();
    send(8'h7F, 8'h01, 0, 8'h80, 0, 1);
    send(8'h80, 8'hFF, 0, 8'h7F, 1, 1);
    send(8'h10, 8'h20, 0, 8'h30, 0, 0);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
